// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory access unit.
//   mem_state_t   : access FSM states (IDLE, REQ, WAIT, DONE)
//   TO_W          : timeout counter width, sized for the largest legal timeout (255)
//   ALIGN_MASK    : low address bits that must be zero for a word access
//   STAT_W        : width of the optional statistics counters
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int unsigned MAX_TIMEOUT = 255;
  localparam int unsigned TO_W        = $clog2(MAX_TIMEOUT + 1);
  localparam logic [1:0]  ALIGN_MASK  = 2'b11;
  localparam int unsigned STAT_W      = 16;

  // True when a byte address is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack memory bus between the access unit and memory.
//   mem_req   : bus request (master -> slave)
//   mem_we    : write enable, valid while mem_req=1
//   mem_addr  : latched byte address
//   mem_wdata : latched store data
//   mem_ack   : acknowledge; mem_rdata valid in the same cycle (slave -> master)
//   mem_rdata : read data
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/access_timeout.sv
// access_timeout: clearable up-counter that stops at a programmable limit.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear to zero (wins over enable)
//   enable     : count one step this cycle (holds once count == limit)
//   limit      : terminal value
//   count      : current count (registered)
//   term_c     : count has reached limit (decode of the count register)
module access_timeout #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         term_c
);

  assign term_c = (count == limit);

  // Saturating count: never advances past limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !term_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: stalls the single-cycle datapath while one load/store is
// carried out on a slower req/ack memory bus.
//   clk, reset          : clock, async active-low reset
//   MemRead, MemWrite   : datapath load/store request (write wins if both)
//   Addr, WriteData     : byte address and store data, latched on accept
//   ReadData            : load result (0 after misalign or timeout)
//   Stall               : high while an access is outstanding (combinational
//                         in the accepting IDLE cycle)
//   bus                 : mem_access_unit_if master (mem_req/we/addr/wdata, mem_ack/rdata)
//   err_clear           : synchronous clear of the sticky errors (set wins)
//   err_misalign        : sticky, misaligned access rejected
//   err_timeout         : sticky, bus access timed out
//   stat_loads/stat_stores/stat_wait_cycles : saturating counters when
//                         MEM_ACCESS_STATS_EN is defined, constant 0 otherwise
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   WriteData,
  output logic [DATA_W-1:0]   ReadData,
  output logic                Stall,
  mem_access_unit_if.master   bus,
  input  logic                err_clear,
  output logic                err_misalign,
  output logic                err_timeout,
  output logic [STAT_W-1:0]   stat_loads,
  output logic [STAT_W-1:0]   stat_stores,
  output logic [STAT_W-1:0]   stat_wait_cycles
);

  // WAIT cycle k sees count k-1, so the limit is one below the timeout.
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  mem_state_t        state, state_nx;
  logic              req_c, misalign_c, accept_c, ack_c, timeout_c, stall_c;
  logic              to_clear, to_enable, to_term;
  logic [TO_W-1:0]   to_count_unused;

  logic              is_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_req_q, mem_we_q;
  logic              err_mis_q, err_to_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle controls; an ack seen in REQ completes like a WAIT ack.
  always_comb begin
    state_nx   = state;
    stall_c    = 1'b0;
    to_clear   = 1'b1;
    to_enable  = 1'b0;
    accept_c   = 1'b0;
    ack_c      = 1'b0;
    timeout_c  = 1'b0;
    req_c      = MemRead | MemWrite;
    misalign_c = is_misaligned(Addr[1:0]);
    unique case (state)
      IDLE: begin
        if (req_c) begin
          stall_c  = 1'b1;
          accept_c = 1'b1;
          state_nx = misalign_c ? DONE : REQ;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (bus.mem_ack) begin
          ack_c    = 1'b1;
          state_nx = DONE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        stall_c   = 1'b1;
        to_clear  = 1'b0;
        to_enable = 1'b1;
        if (bus.mem_ack) begin
          ack_c    = 1'b1;
          state_nx = DONE;
        end else if (to_term) begin
          timeout_c = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Reset must drop Stall at once even if the datapath still holds a request.
  assign Stall = reset & stall_c;

  access_timeout #(.W(TO_W)) u_timeout (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (to_clear),
    .enable (to_enable),
    .limit  (TO_LIMIT),
    .count  (to_count_unused),
    .term_c (to_term)
  );

  // Request latch, bus drive, load data and sticky errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      mem_req_q <= (state_nx == REQ) || (state_nx == WAIT);
      if (accept_c) begin
        addr_q     <= Addr;
        wdata_q    <= WriteData;
        is_write_q <= MemWrite;
        if (misalign_c) begin
          rdata_q <= '0;
        end else begin
          mem_we_q <= MemWrite;
        end
      end
      if (ack_c) begin
        mem_we_q <= 1'b0;
        if (!is_write_q) begin
          rdata_q <= bus.mem_rdata;
        end
      end
      if (timeout_c) begin
        mem_we_q <= 1'b0;
        rdata_q  <= '0;
      end
      err_mis_q <= (accept_c & misalign_c) | (err_mis_q & ~err_clear);
      err_to_q  <= timeout_c | (err_to_q & ~err_clear);
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign ReadData      = rdata_q;
  assign err_misalign  = err_mis_q;
  assign err_timeout   = err_to_q;

`ifdef MEM_ACCESS_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  logic [2:0] stat_sat_unused;

  access_timeout #(.W(STAT_W)) u_stat_loads (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (1'b0),
    .enable (ack_c & ~is_write_q),
    .limit  (STAT_MAX),
    .count  (stat_loads),
    .term_c (stat_sat_unused[0])
  );

  access_timeout #(.W(STAT_W)) u_stat_stores (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (1'b0),
    .enable (ack_c & is_write_q),
    .limit  (STAT_MAX),
    .count  (stat_stores),
    .term_c (stat_sat_unused[1])
  );

  access_timeout #(.W(STAT_W)) u_stat_wait (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (1'b0),
    .enable (Stall),
    .limit  (STAT_MAX),
    .count  (stat_wait_cycles),
    .term_c (stat_sat_unused[2])
  );
`else
  assign stat_loads       = '0;
  assign stat_stores      = '0;
  assign stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit (TIMEOUT_CYCLES=4).
// Expected results come from an access-level model: alignment, ack position
// and timeout decide stall length, bus cycles, ReadData and sticky errors.
module tb_mem_access_unit;

  localparam int T = 4;

  typedef struct {
    int          stall;
    int          req;
    logic [31:0] rd;
    logic        we;
    logic        we_glitch;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic        mis;
    logic        to;
  } obs_t;

  typedef struct {
    int          stall;
    int          req;
    logic [31:0] rd;
    logic        we;
    logic        mis;
    logic        to;
    logic        acked;
  } exp_t;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        MemRead   = 1'b0;
  logic        MemWrite  = 1'b0;
  logic        err_clear = 1'b0;
  logic [31:0] Addr      = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall, err_misalign, err_timeout;
  logic [15:0] stat_loads, stat_stores, stat_wait_cycles;

  int checks = 0;
  int passed = 0;

  logic        exp_mis = 1'b0;
  logic        exp_to  = 1'b0;
  logic [31:0] exp_rd  = '0;
  int exp_loads = 0, exp_stores = 0, exp_wait = 0;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .Addr             (Addr),
    .WriteData        (WriteData),
    .ReadData         (ReadData),
    .Stall            (Stall),
    .bus              (bus),
    .err_clear        (err_clear),
    .err_misalign     (err_misalign),
    .err_timeout      (err_timeout),
    .stat_loads       (stat_loads),
    .stat_stores      (stat_stores),
    .stat_wait_cycles (stat_wait_cycles)
  );

  always #5 clk = ~clk;

  // Access-level reference: what one instruction's access must look like.
  function automatic exp_t model_access(input logic wr, input logic [31:0] addr,
                                        input logic [31:0] rdat, input int ack_k,
                                        input logic [31:0] prev_rd);
    exp_t e;
    e.we = wr; e.mis = 1'b0; e.to = 1'b0; e.acked = 1'b0;
    if (addr[1:0] != 2'b00) begin
      e.stall = 1; e.req = 0; e.rd = '0; e.mis = 1'b1;
    end else if (ack_k >= 0 && ack_k <= T) begin
      e.req = ack_k + 1; e.stall = ack_k + 2; e.acked = 1'b1;
      e.rd = wr ? prev_rd : rdat;
    end else begin
      e.req = T + 1; e.stall = T + 2; e.rd = '0; e.to = 1'b1;
    end
    return e;
  endfunction

  task automatic model_commit(input exp_t e);
    exp_rd   = e.rd;
    exp_mis  = exp_mis | e.mis;
    exp_to   = exp_to | e.to;
    exp_wait = exp_wait + e.stall;
    if (e.acked) begin
      if (e.we) exp_stores++;
      else      exp_loads++;
    end
  endtask

  // Presents one request at a negedge and plays the bus; ack comes in the
  // ack_k-th mem_req cycle (0 = first). Returns when Stall falls (DONE).
  task automatic drive_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdat,
                              input int ack_k, output obs_t o);
    int req_idx;
    o = '{default: 0};
    req_idx = 0;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Addr = addr; WriteData = wd;
    bus.mem_rdata = rdat;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.mem_ack = (bus.mem_req === 1'b1) && (ack_k == req_idx);
      #1;
      if (Stall === 1'b1) o.stall++;
      if (bus.mem_req === 1'b1) begin
        if (req_idx == 0) begin
          o.we = bus.mem_we; o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
        end else if (bus.mem_we !== o.we) begin
          o.we_glitch = 1'b1;
        end
        req_idx++;
      end else if (bus.mem_we !== 1'b0) begin
        o.we_glitch = 1'b1;
      end
      if (Stall === 1'b0) begin
        o.done = 1'b1; o.rd = ReadData; o.mis = err_misalign; o.to = err_timeout;
        MemRead = 1'b0; MemWrite = 1'b0; bus.mem_ack = 1'b0;
        break;
      end
      @(negedge clk);
    end
    o.req = req_idx;
    MemRead = 1'b0; MemWrite = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    reset = 1'b0;
    #12;
    checks++; if (Stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", Stall); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.mem_req); else passed++;
    checks++; if (bus.mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.mem_we); else passed++;
    checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_addr); else passed++;
    checks++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); else passed++;
    checks++; if (ReadData !== 32'h0) $display("FAIL reset_rdata: got %h want 0", ReadData); else passed++;
    checks++; if ({err_misalign, err_timeout} !== 2'b00) $display("FAIL reset_err: got %b want 00", {err_misalign, err_timeout}); else passed++;
    checks++; if ({stat_loads, stat_stores, stat_wait_cycles} !== 48'h0) $display("FAIL reset_stats: got %h want 0", {stat_loads, stat_stores, stat_wait_cycles}); else passed++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++; if ({Stall, bus.mem_req} !== 2'b00) $display("FAIL reset_release_idle: got %b want 00", {Stall, bus.mem_req}); else passed++;
  endtask

  task automatic test_both();
    obs_t o; exp_t e;
    drive_access(1'b1, 1'b1, 32'h10, 32'hA5A5_0010, 32'hDEAD_0001, 2, o);
    e = model_access(1'b1, 32'h10, 32'hDEAD_0001, 2, exp_rd);
    model_commit(e);
    checks++; if (o.done !== 1'b1) $display("FAIL both_done: no DONE within bound"); else passed++;
    checks++; if (o.we !== 1'b1) $display("FAIL both_we: got %b want 1", o.we); else passed++;
    checks++; if (o.stall != e.stall) $display("FAIL both_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.rd !== e.rd) $display("FAIL both_rdata: got %h want %h", o.rd, e.rd); else passed++;
`ifdef MEM_ACCESS_STATS_EN
    checks++; if (stat_stores !== 16'd1) $display("FAIL both_stat_stores: got %0d want 1", stat_stores); else passed++;
    checks++; if (stat_loads !== 16'd0) $display("FAIL both_stat_loads: got %0d want 0", stat_loads); else passed++;
`endif
  endtask

  task automatic test_load();
    obs_t o; exp_t e;
    drive_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 3, o);
    e = model_access(1'b0, 32'h100, 32'hCAFE_F00D, 3, exp_rd);
    model_commit(e);
    checks++; if (o.stall != e.stall) $display("FAIL load_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.req != e.req) $display("FAIL load_req_cycles: got %0d want %0d", o.req, e.req); else passed++;
    checks++; if (o.rd !== e.rd) $display("FAIL load_rdata: got %h want %h", o.rd, e.rd); else passed++;
    checks++; if ({o.we, o.we_glitch} !== 2'b00) $display("FAIL load_we: got %b want 00", {o.we, o.we_glitch}); else passed++;
    checks++; if (o.addr !== 32'h100) $display("FAIL load_addr: got %h want 00000100", o.addr); else passed++;
  endtask

  task automatic test_store();
    obs_t o; exp_t e;
    drive_access(1'b0, 1'b1, 32'h204, 32'h1234_5678, 32'hFFFF_0000, 1, o);
    e = model_access(1'b1, 32'h204, 32'hFFFF_0000, 1, exp_rd);
    model_commit(e);
    checks++; if (o.stall != e.stall) $display("FAIL store_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.we !== 1'b1 || o.we_glitch !== 1'b0) $display("FAIL store_we: got %b/%b want 1/0", o.we, o.we_glitch); else passed++;
    checks++; if (o.wdata !== 32'h1234_5678) $display("FAIL store_wdata: got %h want 12345678", o.wdata); else passed++;
    checks++; if (o.rd !== e.rd) $display("FAIL store_rdata_kept: got %h want %h", o.rd, e.rd); else passed++;
  endtask

  task automatic test_ack_in_req();
    obs_t o; exp_t e;
    drive_access(1'b1, 1'b0, 32'h80, 32'h0, 32'h0BAD_BEEF, 0, o);
    e = model_access(1'b0, 32'h80, 32'h0BAD_BEEF, 0, exp_rd);
    model_commit(e);
    checks++; if (o.stall != e.stall) $display("FAIL ackreq_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.req != e.req) $display("FAIL ackreq_req_cycles: got %0d want %0d", o.req, e.req); else passed++;
    checks++; if (o.rd !== e.rd) $display("FAIL ackreq_rdata: got %h want %h", o.rd, e.rd); else passed++;
  endtask

  task automatic test_ack_at_limit();
    obs_t o; exp_t e;
    drive_access(1'b1, 1'b0, 32'hC0, 32'h0, 32'h7777_1234, T, o);
    e = model_access(1'b0, 32'hC0, 32'h7777_1234, T, exp_rd);
    model_commit(e);
    checks++; if (o.stall != e.stall) $display("FAIL acklim_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.rd !== e.rd) $display("FAIL acklim_rdata: got %h want %h", o.rd, e.rd); else passed++;
    checks++; if (o.to !== exp_to) $display("FAIL acklim_timeout_flag: got %b want %b", o.to, exp_to); else passed++;
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    drive_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h5555_AAAA, -1, o);
    e = model_access(1'b0, 32'h40, 32'h5555_AAAA, -1, exp_rd);
    model_commit(e);
    checks++; if (o.done !== 1'b1) $display("FAIL timeout_done: no DONE within bound"); else passed++;
    checks++; if (o.req != e.req) $display("FAIL timeout_req_cycles: got %0d want %0d", o.req, e.req); else passed++;
    checks++; if (o.stall != e.stall) $display("FAIL timeout_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.rd !== 32'h0) $display("FAIL timeout_rdata: got %h want 0", o.rd); else passed++;
    checks++; if (o.to !== 1'b1) $display("FAIL timeout_flag: got %b want 1", o.to); else passed++;
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0; exp_to = 1'b0; exp_mis = 1'b0;
    checks++; if (err_timeout !== 1'b0) $display("FAIL timeout_clear: got %b want 0", err_timeout); else passed++;
  endtask

  task automatic test_misalign();
    obs_t o; exp_t e;
    drive_access(1'b1, 1'b0, 32'h103, 32'h0, 32'h1111_2222, 0, o);
    e = model_access(1'b0, 32'h103, 32'h1111_2222, 0, exp_rd);
    model_commit(e);
    checks++; if (o.stall != e.stall) $display("FAIL mis_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.req != 0) $display("FAIL mis_req_cycles: got %0d want 0", o.req); else passed++;
    checks++; if (o.rd !== 32'h0) $display("FAIL mis_rdata: got %h want 0", o.rd); else passed++;
    repeat (2) @(negedge clk);
    checks++; if (err_misalign !== 1'b1) $display("FAIL mis_sticky: got %b want 1", err_misalign); else passed++;
    err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0; exp_mis = 1'b0;
    checks++; if (err_misalign !== 1'b0) $display("FAIL mis_clear: got %b want 0", err_misalign); else passed++;
    // err_clear held across a new misaligned accept: the set must win.
    err_clear = 1'b1;
    drive_access(1'b0, 1'b1, 32'h201, 32'h9, 32'h0, 0, o);
    checks++; if (o.mis !== 1'b1) $display("FAIL mis_set_wins: got %b want 1", o.mis); else passed++;
    e = model_access(1'b1, 32'h201, 32'h0, 0, exp_rd);
    model_commit(e);
    @(negedge clk); err_clear = 1'b0; exp_mis = 1'b0;
    checks++; if (err_misalign !== 1'b0) $display("FAIL mis_clear2: got %b want 0", err_misalign); else passed++;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic [31:0] a [3] = '{32'h400, 32'h404, 32'h408};
    int          k [3] = '{2, 0, 1};
    for (int i = 0; i < 3; i++) begin
      drive_access(1'b1, (i == 1), a[i], 32'hB0B0_0000 + 32'(i), 32'hD000_0000 + 32'(i), k[i], o);
      e = model_access((i == 1), a[i], 32'hD000_0000 + 32'(i), k[i], exp_rd);
      model_commit(e);
      checks++; if (o.stall != e.stall) $display("FAIL b2b_stall[%0d]: got %0d want %0d", i, o.stall, e.stall); else passed++;
      checks++; if (o.rd !== e.rd) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, o.rd, e.rd); else passed++;
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [31:0] addr, wd, rdat;
    logic rd, wr;
    int sel, k;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0; exp_mis = 1'b0; exp_to = 1'b0;
      end
      sel  = int'($urandom_range(0, 2));
      rd   = (sel != 1); wr = (sel != 0);
      addr = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
      wd   = $urandom();
      rdat = $urandom();
      k    = int'($urandom_range(0, T + 2));
      drive_access(rd, wr, addr, wd, rdat, k, o);
      e = model_access(wr, addr, rdat, k, exp_rd);
      model_commit(e);
      checks++; if (o.done !== 1'b1) $display("FAIL rnd_done[%0d]: no DONE within bound", n); else passed++;
      checks++; if (o.stall != e.stall) $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, o.stall, e.stall); else passed++;
      checks++; if (o.req != e.req) $display("FAIL rnd_req_cycles[%0d]: got %0d want %0d", n, o.req, e.req); else passed++;
      checks++; if (o.rd !== e.rd) $display("FAIL rnd_rdata[%0d]: got %h want %h", n, o.rd, e.rd); else passed++;
      checks++; if ({o.mis, o.to} !== {exp_mis, exp_to}) $display("FAIL rnd_err[%0d]: got %b want %b", n, {o.mis, o.to}, {exp_mis, exp_to}); else passed++;
      checks++; if (o.we_glitch !== 1'b0) $display("FAIL rnd_we_stable[%0d]: got %b want 0", n, o.we_glitch); else passed++;
      if (e.req > 0) begin
        checks++; if (o.we !== e.we) $display("FAIL rnd_we[%0d]: got %b want %b", n, o.we, e.we); else passed++;
        checks++; if (o.addr !== addr) $display("FAIL rnd_addr[%0d]: got %h want %h", n, o.addr, addr); else passed++;
        if (e.we) begin
          checks++; if (o.wdata !== wd) $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o.wdata, wd); else passed++;
        end
      end
    end
  endtask

  task automatic test_stats();
`ifdef MEM_ACCESS_STATS_EN
    checks++; if (stat_loads !== 16'(exp_loads)) $display("FAIL stat_loads: got %0d want %0d", stat_loads, exp_loads); else passed++;
    checks++; if (stat_stores !== 16'(exp_stores)) $display("FAIL stat_stores: got %0d want %0d", stat_stores, exp_stores); else passed++;
    checks++; if (stat_wait_cycles !== 16'(exp_wait)) $display("FAIL stat_wait: got %0d want %0d", stat_wait_cycles, exp_wait); else passed++;
`else
    checks++; if ({stat_loads, stat_stores, stat_wait_cycles} !== 48'h0) $display("FAIL stat_disabled: got %h want 0", {stat_loads, stat_stores, stat_wait_cycles}); else passed++;
`endif
  endtask

  task automatic test_reset_mid_wait();
    obs_t o; exp_t e;
    @(negedge clk);
    MemRead = 1'b1; Addr = 32'h300; bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) $display("FAIL rmw_req_active: got %b want 1", bus.mem_req); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL rmw_req_drop: got %b want 0", bus.mem_req); else passed++;
    checks++; if (Stall !== 1'b0) $display("FAIL rmw_stall_drop: got %b want 0", Stall); else passed++;
    checks++; if (ReadData !== 32'h0) $display("FAIL rmw_rdata: got %h want 0", ReadData); else passed++;
    checks++; if ({stat_loads, stat_stores, stat_wait_cycles} !== 48'h0) $display("FAIL rmw_stats: got %h want 0", {stat_loads, stat_stores, stat_wait_cycles}); else passed++;
    MemRead = 1'b0;
    @(negedge clk); reset = 1'b1;
    exp_rd = '0; exp_mis = 1'b0; exp_to = 1'b0; exp_loads = 0; exp_stores = 0; exp_wait = 0;
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if ({Stall, bus.mem_req} !== 2'b00) $display("FAIL rmw_spurious_ack[%0d]: got %b want 00", c, {Stall, bus.mem_req}); else passed++;
    end
    bus.mem_ack = 1'b0;
    drive_access(1'b1, 1'b0, 32'h500, 32'h0, 32'h600D_CAFE, 2, o);
    e = model_access(1'b0, 32'h500, 32'h600D_CAFE, 2, exp_rd);
    model_commit(e);
    checks++; if (o.stall != e.stall) $display("FAIL rmw_after_stall: got %0d want %0d", o.stall, e.stall); else passed++;
    checks++; if (o.rd !== e.rd) $display("FAIL rmw_after_rdata: got %h want %h", o.rd, e.rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_both();
    test_load();
    test_store();
    test_ack_in_req();
    test_ack_at_limit();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_random();
    test_stats();
    test_reset_mid_wait();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the single-cycle datapath, between its ALUResult/WriteData/ReadData memory port and a slower memory bus with a req/ack handshake.
- Accepts one load or store per instruction and latches its address and data.
- Stalls the datapath (PC and register write frozen by the controller) until the bus acknowledges, the access times out, or the access is rejected as misaligned.
- Returns load data on ReadData and reports sticky error status.

Parameters:
- ADDR_W, 32, address width (datapath ALUResult width).
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT before abort; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemRead  input  1  datapath load request (MemtoReg qualified by the controller).
- MemWrite  input  1  datapath store request.
- Addr  input  ADDR_W  byte address from ALUResult.
- WriteData  input  DATA_W  store data from the register file.
- ReadData  output  DATA_W  load result to the result mux.
- Stall  output  1  freezes the datapath while an access is outstanding.
- mem_req  output  1  bus request.
- mem_we  output  1  bus write enable, valid while mem_req=1.
- mem_addr  output  ADDR_W  latched address.
- mem_wdata  output  DATA_W  latched store data.
- mem_ack  input  1  bus acknowledge; rdata is valid in the same cycle.
- mem_rdata  input  DATA_W  bus read data.
- err_misalign  output  1  sticky: a misaligned access was rejected.
- err_timeout  output  1  sticky: a bus access timed out.
- err_clear  input  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (reset=0, async): state=IDLE. Stall, mem_req, mem_we, err_* = 0. mem_addr, mem_wdata, ReadData = 0. Timeout counter = 0. Applies immediately mid-access; mem_req drops without waiting for ack.
- State machine: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Request = MemRead|MemWrite. If both are asserted, the write wins.
  - On a request, Stall=1 combinationally in the same cycle.
  - Addr, WriteData and write/read are latched at the clock edge.
  - If Addr[1:0]≠0: no bus access; set err_misalign; ReadData←0; go to DONE.
  - Otherwise go to REQ.
  - mem_ack while IDLE is ignored.
- REQ:
  - mem_req=1, Stall=1, counter cleared; go to WAIT.
  - If mem_ack is already high in this cycle, it is treated as the WAIT ack below.
- WAIT:
  - mem_req=1, Stall=1, counter increments.
  - On mem_ack=1: ReadData←mem_rdata (loads only; stores leave ReadData unchanged); next cycle mem_req=0; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: mem_req=0, set err_timeout, ReadData←0, go to DONE.
  - Ack has priority over timeout in the same cycle.
- DONE:
  - Stall=0 for exactly one cycle, so the datapath completes the instruction and writes back ReadData.
  - No new request is accepted in DONE; always return to IDLE.
- Latency:
  - Access with ack in cycle k of WAIT: Stall is high for 2+k cycles.
  - Misaligned access: Stall is high for 1 cycle.
- Back-to-back: a request held through DONE is not re-accepted. The datapath presents the next instruction's request in the cycle after DONE.
- err_clear in the same cycle as a new error event: set wins.
- The bus must hold mem_rdata valid while mem_ack=1. Ack is sampled only in REQ/WAIT.

Optional Feature:
- MEM_ACCESS_STATS_EN defined: adds 16-bit saturating counters, cleared by reset, exposed on outputs stat_loads, stat_stores and stat_wait_cycles.
  - stat_loads / stat_stores: incremented on each completed ack.
  - stat_wait_cycles: incremented for every cycle with Stall=1.
- Undefined: the three ports are still present, driven constant 0, and no counter logic is synthesized.

Decomposition:
- Package mem_access_pkg:
  - mem_state_t enum {IDLE, REQ, WAIT, DONE}.
  - localparam TO_W = $clog2(TIMEOUT_CYCLES+1).
  - ALIGN_MASK = 2'b11.
  - STAT_W = 16.
- One sub-module, access_timeout: clear/enable/limit inputs, terminal-count output. Used for WAIT supervision and reused by the stats counters with saturation.

Test Plan:
- Aligned load: Addr=0x100, mem_ack 3 cycles after mem_req rises, mem_rdata=0xCAFEF00D -> Stall high 5 cycles; ReadData=0xCAFEF00D in DONE; mem_we=0 throughout.
- Aligned store: Addr=0x204, WriteData=0x12345678, ack in the first WAIT cycle -> mem_we=1, mem_wdata=0x12345678; Stall high 3 cycles; ReadData unchanged.
- Misaligned access: Addr=0x103, MemRead=1 -> mem_req never asserts; Stall high 1 cycle; err_misalign=1 until err_clear pulses.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> mem_req high exactly 5 cycles, then 0; err_timeout=1; ReadData=0; DONE reached.
- Reset mid-WAIT: reset=0 asynchronously -> mem_req and Stall go 0 before the next clock edge; after reset=1, a spurious mem_ack in IDLE causes no state change.
- MemRead=MemWrite=1 at Addr=0x10 -> write performed (mem_we=1); with MEM_ACCESS_STATS_EN, stat_stores=1 and stat_loads=0.
